// File: rtl/irq_pkg.sv
// Shared constants for the interrupt vector controller: register offsets,
// FSM state encoding and ACTIVE register layout.
package irq_pkg;

    localparam logic [3:0] REG_PEND_L = 4'd0;
    localparam logic [3:0] REG_PEND_H = 4'd1;
    localparam logic [3:0] REG_MASK_L = 4'd2;
    localparam logic [3:0] REG_MASK_H = 4'd3;
    localparam logic [3:0] REG_EDGE_L = 4'd4;
    localparam logic [3:0] REG_EDGE_H = 4'd5;
    localparam logic [3:0] REG_ACTIVE = 4'd6;
    localparam logic [3:0] REG_EOI    = 4'd7;
    localparam logic [3:0] REG_VEC_H  = 4'd8;
    localparam logic [3:0] REG_VEC_L  = 4'd9;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam int unsigned ACTIVE_VALID_BIT = 7;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt channel: input synchroniser, history flop and edge/level detect.
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          IRQ_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic edge_det,
    output logic level
);

    // Raw level of an idle (de-asserted) source; XOR with it yields "asserted".
    localparam logic IDLE_LVL = IRQ_ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   edge_q;
    logic                   cur_asserted;
    logic                   hist_asserted;

    assign cur_asserted  = sync[SYNC_STAGES-1] ^ IDLE_LVL;
    assign hist_asserted = hist ^ IDLE_LVL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= {SYNC_STAGES{IDLE_LVL}};
            hist   <= IDLE_LVL;
            edge_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], src};
            hist   <= sync[SYNC_STAGES-1];
            edge_q <= cur_asserted & ~hist_asserted;
        end
    end

    assign edge_det = edge_q;
    assign level    = hist_asserted;

endmodule

// File: rtl/irq_vector_ctrl.sv
// Multi-channel interrupt controller: masked, fixed-priority arbitration onto a
// single active-low CPU request, with a byte-wide register window and EOI.
module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ        = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          IRQ_ACTIVE_LOW = 1'b1,
    parameter int unsigned IRQ_PULSE      = 2,
    parameter logic [15:0] VECTOR_BASE    = 16'h0100,
    parameter logic [15:0] VECTOR_STRIDE  = 16'h0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               sel,
    input  logic [3:0]         addr,
    input  logic               rd,
    input  logic               wr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               irq_n,
    output logic               busy
);

    localparam logic [15:0] VALID = 16'((32'd1 << NUM_IRQ) - 32'd1);

    logic [15:0] edge_det;
    logic [15:0] level;
    logic [15:0] pending;
    logic [15:0] mask;
    logic [15:0] edge_mode;
    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        eoi_pend;
    logic        eoi_next;
    logic [3:0]  active_id;
    logic [3:0]  id_next;
    logic        irq_n_next;
    logic        busy_next;
    logic        claim;
    logic [15:0] req;
    logic [3:0]  winner;
    logic        wr_en;
    logic        eoi;
    logic [15:0] w1c;
    logic [15:0] claim_clr;
    logic [15:0] pending_next;
    logic [15:0] vector;
    logic [7:0]  active_reg;
    logic [7:0]  rd_val;

    for (genvar g = 0; g < 16; g++) begin : g_chan
        if (g < NUM_IRQ) begin : g_used
            irq_sync_edge #(
                .SYNC_STAGES   (SYNC_STAGES),
                .IRQ_ACTIVE_LOW(IRQ_ACTIVE_LOW)
            ) u_sync (
                .clk     (clk),
                .rst     (rst),
                .src     (irq_src[g]),
                .edge_det(edge_det[g]),
                .level   (level[g])
            );
        end else begin : g_unused
            assign edge_det[g] = 1'b0;
            assign level[g]    = 1'b0;
        end
    end

    assign wr_en = sel & wr;
    assign eoi   = wr_en && (addr == REG_EOI);
    assign req   = pending & mask;

    // Lowest index wins.
    always_comb begin
        winner = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) winner = 4'(i);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        eoi_next   = eoi_pend;
        id_next    = active_id;
        irq_n_next = irq_n;
        busy_next  = busy;
        claim      = 1'b0;
        case (state)
            ST_IDLE: begin
                eoi_next = 1'b0;
                if (req != 16'd0) begin
                    claim      = 1'b1;
                    id_next    = winner;
                    state_next = ST_REQ;
                    irq_n_next = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = 4'(IRQ_PULSE - 1);
                end
            end
            ST_REQ: begin
                if (eoi) eoi_next = 1'b1;
                if (cnt == 4'd0) begin
                    irq_n_next = 1'b1;
                    state_next = ST_SERVICE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_SERVICE: begin
                // An EOI seen during the pulse is honoured here, keeping the minimum request gap.
                if (eoi || eoi_pend) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    eoi_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                irq_n_next = 1'b1;
                busy_next  = 1'b0;
                eoi_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            eoi_pend  <= 1'b0;
            active_id <= 4'd0;
            irq_n     <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            eoi_pend  <= eoi_next;
            active_id <= id_next;
            irq_n     <= irq_n_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        w1c = 16'd0;
        if (wr_en && addr == REG_PEND_L) w1c = {8'd0, wdata};
        if (wr_en && addr == REG_PEND_H) w1c = {wdata, 8'd0};
    end

    assign claim_clr = claim ? (16'd1 << winner) : 16'd0;

    // Edge bits: sticky with W1C and claim clear, a new edge wins; level bits track the input.
    assign pending_next = ((edge_mode & ((pending & ~w1c & ~claim_clr) | edge_det))
                          | (~edge_mode & level)) & VALID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 16'd0;
            mask      <= 16'd0;
            edge_mode <= VALID;
        end else begin
            pending <= pending_next;
            if (wr_en && addr == REG_MASK_L) mask[7:0]       <= wdata & VALID[7:0];
            if (wr_en && addr == REG_MASK_H) mask[15:8]      <= wdata & VALID[15:8];
            if (wr_en && addr == REG_EDGE_L) edge_mode[7:0]  <= wdata & VALID[7:0];
            if (wr_en && addr == REG_EDGE_H) edge_mode[15:8] <= wdata & VALID[15:8];
        end
    end

    assign vector = VECTOR_BASE + VECTOR_STRIDE * {12'd0, active_id};

    always_comb begin
        active_reg                   = 8'd0;
        active_reg[ACTIVE_VALID_BIT] = busy;
        active_reg[3:0]              = active_id;
    end

    always_comb begin
        rd_val = 8'd0;
        case (addr)
            REG_PEND_L: rd_val = pending[7:0];
            REG_PEND_H: rd_val = pending[15:8];
            REG_MASK_L: rd_val = mask[7:0];
            REG_MASK_H: rd_val = mask[15:8];
            REG_EDGE_L: rd_val = edge_mode[7:0];
            REG_EDGE_H: rd_val = edge_mode[15:8];
            REG_ACTIVE: rd_val = active_reg;
            REG_VEC_H:  rd_val = vector[15:8];
            REG_VEC_L:  rd_val = vector[7:0];
            default:    rd_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'd0;
        end else if (sel && rd) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed plus randomized checks of irq_vector_ctrl (12-channel build, active-low sources).
module tb_irq_vector_ctrl;

    localparam int unsigned N = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src;
    logic         sel;
    logic [3:0]   addr;
    logic         rd;
    logic         wr;
    logic [7:0]   wdata;
    logic [7:0]   rdata;
    logic         irq_n;
    logic         busy;

    int checks = 0;
    int errors = 0;

    irq_vector_ctrl #(
        .NUM_IRQ       (N),
        .SYNC_STAGES   (2),
        .IRQ_ACTIVE_LOW(1'b1),
        .IRQ_PULSE     (2),
        .VECTOR_BASE   (16'h0100),
        .VECTOR_STRIDE (16'h0010)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_src(src),
        .sel    (sel),
        .addr   (addr),
        .rd     (rd),
        .wr     (wr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq_n  (irq_n),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        sel = 1'b1; rd = 1'b1; addr = a;
        tick();
        sel = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(a, d);
        chk(tag, 16'(d), 16'(exp));
    endtask

    // Bounded wait for irq_n to reach a level.
    task automatic wait_irq(input string tag, input logic val);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (irq_n === val) seen = 1'b1;
        end
        chk(tag, 16'(seen), 16'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (irq_n !== 1'b1) ok = 1'b0;
        end
        chk(tag, 16'(ok), 16'd1);
    endtask

    function automatic logic [15:0] exp_vec(input int id);
        return 16'(32'h0100 + id * 32'h0010);
    endfunction

    initial begin
        logic [N-1:0] e;
        logic [N-1:0] m;
        logic [N-1:0] left;

        rst = 1'b1; src = '1; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'd0; wdata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq_n", 16'(irq_n), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_rdata", 16'(rdata), 16'd0);
        rst = 1'b0;
        tick();

        // Idle sources with all channels enabled: no request.
        bus_wr(4'd2, 8'hFF);
        quiet("idle_quiet", 50);
        rd_chk("idle_pend_l", 4'd0, 8'h00);
        rd_chk("edge_l_reset", 4'd4, 8'hFF);
        rd_chk("edge_h_reset", 4'd5, 8'h0F);
        bus_wr(4'd3, 8'hFF);
        rd_chk("mask_h_trunc", 4'd3, 8'h0F);

        // Single edge on channel 3: exact latency and pulse width.
        src[3] = 1'b0;
        repeat (4) tick();
        chk("lat_before", 16'(irq_n), 16'd1);
        tick();
        chk("lat_low0", 16'(irq_n), 16'd0);
        tick();
        chk("lat_low1", 16'(irq_n), 16'd0);
        tick();
        chk("pulse_end", 16'(irq_n), 16'd1);
        rd_chk("ch3_active", 4'd6, 8'h83);
        rd_chk("ch3_vec_h", 4'd8, 8'h01);
        rd_chk("ch3_vec_l", 4'd9, 8'h30);
        rd_chk("ch3_pend", 4'd0, 8'h00);
        src[3] = 1'b1;
        bus_wr(4'd7, 8'h00);
        chk("eoi_busy", 16'(busy), 16'd0);

        // Simultaneous edges on channels 5 and 2: priority order.
        src[5] = 1'b0; src[2] = 1'b0;
        wait_irq("pair_req1", 1'b0);
        rd_chk("pair_first", 4'd6, 8'h82);
        wait_irq("pair_end1", 1'b1);
        bus_wr(4'd7, 8'h00);
        wait_irq("pair_req2", 1'b0);
        rd_chk("pair_second", 4'd6, 8'h85);
        wait_irq("pair_end2", 1'b1);
        bus_wr(4'd7, 8'h00);
        src[5] = 1'b1; src[2] = 1'b1;
        quiet("pair_quiet", 10);

        // Level mode on channel 1.
        bus_wr(4'd4, 8'hFD);
        bus_wr(4'd2, 8'h02);
        src[1] = 1'b0;
        wait_irq("lvl_req1", 1'b0);
        rd_chk("lvl_active", 4'd6, 8'h81);
        wait_irq("lvl_end1", 1'b1);
        bus_wr(4'd7, 8'h00);
        wait_irq("lvl_req2", 1'b0);
        wait_irq("lvl_end2", 1'b1);
        src[1] = 1'b1;
        repeat (8) tick();
        bus_wr(4'd7, 8'h00);
        quiet("lvl_released", 20);
        rd_chk("lvl_pend", 4'd0, 8'h00);
        bus_wr(4'd4, 8'hFF);

        // Masked edge on channel 0, then unmask.
        bus_wr(4'd2, 8'h00);
        src[0] = 1'b0;
        repeat (8) tick();
        chk("masked_no_req", 16'(irq_n), 16'd1);
        rd_chk("masked_pend", 4'd0, 8'h01);
        bus_wr(4'd2, 8'h01);
        wait_irq("unmask_req", 1'b0);
        rd_chk("unmask_active", 4'd6, 8'h80);
        wait_irq("unmask_end", 1'b1);
        bus_wr(4'd7, 8'h00);
        src[0] = 1'b1;
        quiet("ch0_no_repeat", 10);

        // W1C of a masked pending bit before unmasking.
        bus_wr(4'd2, 8'h00);
        src[0] = 1'b0;
        repeat (8) tick();
        rd_chk("w1c_pre", 4'd0, 8'h01);
        bus_wr(4'd0, 8'h01);
        rd_chk("w1c_post", 4'd0, 8'h00);
        bus_wr(4'd2, 8'h01);
        quiet("w1c_quiet", 10);
        src[0] = 1'b1;
        bus_wr(4'd2, 8'h00);

        // Reset during REQ.
        bus_wr(4'd2, 8'h10);
        src[4] = 1'b0;
        wait_irq("rstreq_low", 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rstreq_irq_n", 16'(irq_n), 16'd1);
        chk("rstreq_busy", 16'(busy), 16'd0);
        src[4] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        rd_chk("rstreq_active", 4'd6, 8'h00);
        rd_chk("rstreq_mask", 4'd2, 8'h00);
        quiet("rstreq_quiet", 10);

        // Randomized rounds: service order is ascending over edge&mask; masked edges stay pending.
        for (int r = 0; r < 12; r++) begin
            e = N'($urandom);
            if (e == '0) e = N'(1);
            m = N'($urandom);
            bus_wr(4'd2, m[7:0]);
            bus_wr(4'd3, 8'(m[N-1:8]));
            src = ~e;
            left = e & m;
            for (int id = 0; id < int'(N); id++) begin
                if (left[id]) begin
                    wait_irq("rnd_req", 1'b0);
                    rd_chk("rnd_active", 4'd6, 8'h80 | 8'(id));
                    rd_chk("rnd_vec_h", 4'd8, exp_vec(id) >> 8);
                    rd_chk("rnd_vec_l", 4'd9, 8'(exp_vec(id)));
                    wait_irq("rnd_end", 1'b1);
                    bus_wr(4'd7, 8'(r));
                end
            end
            quiet("rnd_quiet", 12);
            chk("rnd_busy", 16'(busy), 16'd0);
            left = e & ~m;
            rd_chk("rnd_pend_l", 4'd0, left[7:0]);
            rd_chk("rnd_pend_h", 4'd1, 8'(left[N-1:8]));
            src = '1;
            bus_wr(4'd0, 8'hFF);
            bus_wr(4'd1, 8'hFF);
            repeat (4) tick();
            rd_chk("rnd_clr", 4'd0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
- Parametrised, multi-channel successor to the core's single-line interrupt input.
- Collects up to NUM_IRQ peripheral interrupt sources and applies per-channel mask and edge/level mode.
- Arbitrates by fixed priority and presents one falling-edge request on irq_n to the CPU interrupt pin.
- Exposes the winning channel ID and its computed 16-bit handler vector through a small byte-wide register window on the system bus, with explicit end-of-interrupt (EOI).

Parameters:
- NUM_IRQ, 8, number of source channels, legal range 1..16; bits at and above NUM_IRQ read 0 and ignore writes.
- SYNC_STAGES, 2, synchroniser flops per source input, range 2..3.
- IRQ_ACTIVE_LOW, 1, source polarity: 1 = falling edge / low level asserts; 0 = rising edge / high level asserts.
- IRQ_PULSE, 2, number of cycles irq_n is held low per request, range 1..15.
- VECTOR_BASE, 16'h0100, vector of channel 0.
- VECTOR_STRIDE, 16'h0010, vector spacing between channels.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- irq_src  in  NUM_IRQ  raw asynchronous interrupt sources.
- sel  in  1  register window select, decoded externally.
- addr  in  4  register offset.
- rd  in  1  read strobe; qualified by sel.
- wr  in  1  write strobe; qualified by sel.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- irq_n  out  1  request to CPU interrupt pin, active low.
- busy  out  1  high while a request is issued or in service.

Behaviour:
- Reset, asynchronous while rst is high:
  - irq_n=1, busy=0, rdata=0.
  - pending=0, mask=0 (all channels disabled), edge_mode=all 1, FSM=IDLE, active_id=0.
  - Synchronisers load the de-asserted level, so no spurious edge after reset release.
- Reset mid-request: irq_n returns high immediately; the claimed channel is lost, not re-queued.
- Source path: synchroniser, then a one-flop history register, then detect.
  - Edge mode: an assertion edge sets pending[i].
  - Level mode: pending[i] follows the synchronised asserted level.
- Latency: source edge sampled at posedge k → pending visible at k+SYNC_STAGES+1 → irq_n low on the following cycle (total SYNC_STAGES+2).
- Register map (16-bit fields split into two bytes; _L = bits 7:0, _H = bits 15:8):
  - 0 PEND_L, 1 PEND_H: read pending. Write-1-to-clear acts on edge-mode bits only.
  - 2 MASK_L, 3 MASK_H: read/write; 1 = enabled.
  - 4 EDGE_L, 5 EDGE_H: read/write; 1 = edge mode, 0 = level mode.
  - 6 ACTIVE: read-only; bit7 = in service, bits3:0 = active_id.
  - 7 EOI: write of any value ends service.
  - 8 VEC_H, 9 VEC_L: read-only; VECTOR_BASE + active_id*VECTOR_STRIDE, truncated to 16 bits.
  - 10..15: read 0, writes ignored.
- Reads: rdata is updated on the posedge where sel&rd is high, valid from the next cycle; it holds its value otherwise.
- Write and edge-set in the same cycle on the same bit: set wins.
- FSM IDLE:
  - Condition for a request: (pending & mask) != 0.
  - Winner = lowest set index.
  - Action: capture active_id; clear pending[winner] if that channel is edge mode; go to REQ; irq_n=0; busy=1.
- FSM REQ:
  - irq_n is held low for IRQ_PULSE cycles, then driven high and the FSM moves to SERVICE.
  - EOI in REQ is latched and honoured on entry to SERVICE.
- FSM SERVICE:
  - irq_n stays high; no preemption.
  - New pendings accumulate.
  - EOI → IDLE and busy=0, effective next cycle.
  - EOI outside REQ/SERVICE is ignored.
- Level-mode channel still asserted after EOI: it re-arbitrates and re-requests from IDLE. The minimum gap between irq_n falling edges is IRQ_PULSE+2 cycles.
- Mask or mode changes affect only future arbitration; an already-claimed channel completes.
- Changing a channel from edge to level mode clears nothing; level tracking takes over from the next cycle.

Decomposition:
- Shared package irq_pkg holds:
  - register offset constants (REG_PEND_L .. REG_VEC_L);
  - the FSM state encoding (IDLE, REQ, SERVICE);
  - the ACTIVE bit7 valid position.
- Sub-module irq_sync_edge: one channel's synchroniser plus edge/level detect, parametrised by SYNC_STAGES and IRQ_ACTIVE_LOW, instantiated NUM_IRQ times via generate.
- The priority encoder and register file stay in the top level.

Test Plan:
- Reset release with all sources idle, then write MASK_L=8'hFF → irq_n stays 1 for 50 cycles; PEND_L reads 8'h00.
- Falling edge on irq_src[3], edge mode, enabled →
  - irq_n low at edge+4 cycles for exactly 2 cycles;
  - ACTIVE reads 8'h83; VEC_H/VEC_L read 8'h01/8'h30;
  - PEND_L bit3 reads 0.
- Edges on channels 5 and 2 in the same cycle →
  - first request: ACTIVE=8'h82;
  - after EOI write: second irq_n pulse with ACTIVE=8'h85.
- Channel 1 in level mode (EDGE_L=8'hFD), source held low across EOI → a second irq_n pulse follows; releasing the source before EOI gives no second pulse.
- Masked edge on channel 0 (MASK_L=0) → PEND_L=8'h01 with no request; then write MASK_L=8'h01 → request issues; PEND_L write of 8'h01 in IDLE before unmasking clears the pending bit.
- rst asserted while in REQ → irq_n returns high asynchronously; ACTIVE=0 and MASK_L=0 after release; NUM_IRQ=12 build: PEND_H bits 7:4 always read 0.
